// File: rtl/pl_pipe.sv
// rtl/pl_pipe.sv - elastic valid/ready pipeline-register chain with stall, flush, kill and occupancy
module pl_pipe #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] NOP_VAL = WIDTH'(32'h00000013),
    parameter int               CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [CNT_W-1:0]            r_occ;

    logic [DEPTH-1:0]            w_live;
    logic [DEPTH-1:0]            w_rdy;
    logic [DEPTH-1:0]            w_src_v;
    logic [DEPTH-1:0][WIDTH-1:0] w_src_data;
    logic [DEPTH-1:0]            w_v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] w_data_nxt;
    logic [CNT_W-1:0]            w_cnt_nxt;

    assign w_live = r_v & ~flush_mask;

    // A stage may load whenever any stage at or after it can make room, so bubbles collapse.
    always_comb begin
        w_rdy            = '0;
        w_rdy[DEPTH-1]   = out_ready | ~w_live[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_rdy[i] = w_rdy[i+1] | ~w_live[i];
        end
    end

    always_comb begin
        w_src_v       = '0;
        w_src_data    = '0;
        w_src_v[0]    = in_valid;
        w_src_data[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_v[i]    = w_live[i-1];
            w_src_data[i] = r_data[i-1];
        end
    end

    always_comb begin
        w_v_nxt    = r_v;
        w_data_nxt = r_data;
        if (flush) begin
            w_v_nxt = '0;
            for (int i = 0; i < DEPTH; i++) begin
                w_data_nxt[i] = NOP_VAL;
            end
        end else if (stall) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_mask[i]) begin
                    w_v_nxt[i]    = 1'b0;
                    w_data_nxt[i] = NOP_VAL;
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    w_v_nxt[i]    = w_src_v[i];
                    w_data_nxt[i] = w_src_v[i] ? w_src_data[i] : NOP_VAL;
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v    <= '0;
            r_data <= {DEPTH{NOP_VAL}};
            r_occ  <= '0;
        end else begin
            r_v    <= w_v_nxt;
            r_data <= w_data_nxt;
            r_occ  <= w_cnt_nxt;
        end
    end

    // Gated by rst so nothing is accepted while the chain is held in reset.
    assign in_ready  = w_rdy[0] & ~stall & ~flush & rst;
    assign out_valid = w_live[DEPTH-1] & ~stall & ~flush;
    assign out_data  = out_valid ? r_data[DEPTH-1] : NOP_VAL;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pl_pipe.sv
// tb/tb_pl_pipe.sv - directed and randomized checks of pl_pipe against a slot-list reference model
module tb_pl_pipe;

    localparam int          D   = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        stall;
    logic        flush;
    logic [D-1:0] flush_mask;
    logic [2:0]  occupancy;

    pl_pipe #(.WIDTH(32), .DEPTH(D), .NOP_VAL(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall      (stall),
        .flush      (flush),
        .flush_mask (flush_mask),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          m_v[D];
    logic [31:0] m_d[D];
    logic [31:0] out_log[$];
    int          out_cyc[$];
    int          acc_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = NOP;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_v[i]);
        return n;
    endfunction

    // One clock: check combinational outputs at the falling edge, advance the model, check occupancy.
    task automatic cycle();
        bit          live[D];
        bit          nv[D];
        logic [31:0] nd[D];
        bit          has_hole;
        bit          e_ir;
        bit          e_ov;
        logic [31:0] e_od;
        int          k;
        @(negedge clk);
        has_hole = 1'b0;
        for (int i = 0; i < D; i++) begin
            live[i] = m_v[i] && !flush_mask[i];
            if (!live[i]) has_hole = 1'b1;
            nv[i] = m_v[i];
            nd[i] = m_d[i];
        end
        e_ir = (rst === 1'b1) && !stall && !flush && (out_ready || has_hole);
        e_ov = live[D-1] && !stall && !flush;
        e_od = e_ov ? m_d[D-1] : NOP;
        chk("in_ready", {31'b0, in_ready}, {31'b0, e_ir});
        chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
        chk("out_data", out_data, e_od);
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            out_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (rst !== 1'b1) begin
            for (int i = 0; i < D; i++) begin nv[i] = 1'b0; nd[i] = NOP; end
        end else if (flush) begin
            for (int i = 0; i < D; i++) begin nv[i] = 1'b0; nd[i] = NOP; end
        end else if (stall) begin
            for (int i = 0; i < D; i++) if (flush_mask[i]) begin nv[i] = 1'b0; nd[i] = NOP; end
        end else begin
            // Tail run of live words that cannot leave stays put; everything ahead of it advances one slot.
            k = D;
            if (!out_ready) while (k > 0 && live[k-1]) k--;
            for (int i = 0; i < k; i++) begin
                if (i == 0) begin
                    nv[0] = in_valid;
                    nd[0] = in_valid ? in_data : NOP;
                end else begin
                    nv[i] = live[i-1];
                    nd[i] = live[i-1] ? m_d[i-1] : NOP;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < D; i++) begin m_v[i] = nv[i]; m_d[i] = nd[i]; end
        chk("occupancy", {29'b0, occupancy}, 32'(model_count()));
    endtask

    task automatic push4(input logic [31:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0; flush_mask = '0;
        model_reset();
        repeat (3) cycle();
        chk("rst_occ", {29'b0, occupancy}, 32'd0);
        chk("rst_out_data", out_data, NOP);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        out_ready = 1'b1;
        out_log.delete(); out_cyc.delete(); acc_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            cycle();
            if (i >= 3) chk("stream_occ", {29'b0, occupancy}, 32'd4);
        end
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("stream_empty", {29'b0, occupancy}, 32'd0);
        chk("stream_count", 32'(out_log.size()), 32'd8);
        if (out_cyc.size() > 0 && acc_cyc.size() > 0)
            chk("stream_latency", 32'(out_cyc[0] - acc_cyc[0]), 32'd4);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("stream_order", out_log[i], 32'h100 + 32'(i));

        out_log.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; cycle();
        in_valid = 1'b0; repeat (2) cycle();
        in_valid = 1'b1; in_data = 32'hB; cycle();
        in_valid = 1'b0;
        chk("bp_occ2", {29'b0, occupancy}, 32'd2);
        in_valid = 1'b1; in_data = 32'hC; cycle();
        in_data = 32'hD; cycle();
        in_valid = 1'b0;
        #1;
        chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_occ4", {29'b0, occupancy}, 32'd4);
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("bp_count", 32'(out_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            chk("bp_order", out_log[i], 32'hA + 32'(i));

        out_log.delete();
        push4(32'hA1);
        out_ready = 1'b1; flush_mask = 4'b0010;
        cycle();
        flush_mask = '0;
        chk("kill_occ", {29'b0, occupancy}, 32'd2);
        repeat (5) cycle();
        chk("kill_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            chk("kill_0", out_log[0], 32'hA1);
            chk("kill_1", out_log[1], 32'hA2);
            chk("kill_2", out_log[2], 32'hA4);
        end

        push4(32'hB1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        stall = 1'b1; flush_mask = 4'b1000;
        #1;
        chk("stall_out_valid", {31'b0, out_valid}, 32'd0);
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        cycle();
        stall = 1'b0; flush_mask = '0; in_valid = 1'b0; out_ready = 1'b0;
        chk("stall_occ", {29'b0, occupancy}, 32'd3);

        out_log.delete();
        flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        cycle();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        chk("flush_occ", {29'b0, occupancy}, 32'd0);
        chk("flush_last", dut.r_data[D-1], NOP);
        out_ready = 1'b1;
        repeat (5) cycle();
        chk("flush_nothing_out", 32'(out_log.size()), 32'd0);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h300 + 32'(i);
            cycle();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_data", out_data, NOP);
        chk("arst_occ", {29'b0, occupancy}, 32'd0);
        model_reset();
        in_valid = 1'b0;
        cycle();
        rst = 1'b1;

        repeat (400) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = $urandom;
            out_ready  = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 15) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            flush_mask = ($urandom_range(0, 7) == 0) ? D'($urandom) : '0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
